// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the FP divider scheduler and its arbiter.
package div_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } div_sched_state_t;

    localparam int unsigned DIV_N       = 48;
    localparam int unsigned DIV_LATENCY = 24;

    // Requester id width; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after the pointer.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant_c,
    output logic [IDW-1:0]  o_id_c
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        o_grant_c = '0;
        o_id_c    = '0;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(i_ptr) + k) % NREQ);
            if (i_en && !w_found && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_id_c           = w_idx;
                w_found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one iterative unsigned divider between NREQ requesters: round-robin accept,
// fixed-latency run, result hold until consumed; divide-by-zero bypasses the divider.
module div_scheduler #(
    parameter  int unsigned N           = div_sched_pkg::DIV_N,
    parameter  int unsigned NREQ        = 2,
    parameter  int unsigned DIV_LATENCY = div_sched_pkg::DIV_LATENCY,
    localparam int unsigned HW          = N / 2,
    localparam int unsigned IDW         = div_sched_pkg::id_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][N-1:0]   req_m,
    input  logic [NREQ-1:0][N-1:0]   req_q,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [HW-1:0]            rsp_quotient,
    output logic [HW-1:0]            rsp_remainder,
    output logic                     rsp_dbz,
    output logic                     busy,
    output logic                     div_rstn,
    output logic [N-1:0]             div_m,
    output logic [N-1:0]             div_q,
    input  logic [HW-1:0]            div_quotient,
    input  logic [HW-1:0]            div_remainder
);

    localparam int unsigned CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    div_sched_pkg::div_sched_state_t r_state, w_state_nxt;

    logic [IDW-1:0]  r_ptr, w_ptr_nxt;
    logic [IDW-1:0]  r_id, w_id_nxt;
    logic [HW-1:0]   r_quot, w_quot_nxt;
    logic [HW-1:0]   r_rem, w_rem_nxt;
    logic            r_dbz, w_dbz_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_div_rstn, w_div_rstn_nxt;
    logic [N-1:0]    r_div_m, w_div_m_nxt;
    logic [N-1:0]    r_div_q, w_div_q_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_arb_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;

    assign w_arb_en = (r_state == div_sched_pkg::S_IDLE);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .i_en      (w_arb_en),
        .o_grant_c (w_gnt),
        .o_id_c    (w_gnt_id)
    );

    // State and datapath registers; reset parks the divider in reset and drops any result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= div_sched_pkg::S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_div_rstn  <= 1'b0;
            r_div_m     <= '0;
            r_div_q     <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_id        <= w_id_nxt;
            r_quot      <= w_quot_nxt;
            r_rem       <= w_rem_nxt;
            r_dbz       <= w_dbz_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_div_rstn  <= w_div_rstn_nxt;
            r_div_m     <= w_div_m_nxt;
            r_div_q     <= w_div_q_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_id_nxt        = r_id;
        w_quot_nxt      = r_quot;
        w_rem_nxt       = r_rem;
        w_dbz_nxt       = r_dbz;
        w_rsp_valid_nxt = r_rsp_valid;
        w_div_rstn_nxt  = 1'b0;
        w_div_m_nxt     = r_div_m;
        w_div_q_nxt     = r_div_q;
        w_cnt_nxt       = r_cnt;

        unique case (r_state)
            div_sched_pkg::S_IDLE: begin
                if (|w_gnt) begin
                    w_div_m_nxt = req_m[w_gnt_id];
                    w_div_q_nxt = req_q[w_gnt_id];
                    w_id_nxt    = w_gnt_id;
                    w_ptr_nxt   = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + IDW'(1);
                    if (req_m[w_gnt_id] == '0) begin
                        w_state_nxt     = div_sched_pkg::S_HOLD;
                        w_dbz_nxt       = 1'b1;
                        w_quot_nxt      = '1;
                        w_rem_nxt       = '0;
                        w_rsp_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = div_sched_pkg::S_LOAD;
                    end
                end
            end
            div_sched_pkg::S_LOAD: begin
                // One cycle of divider reset, then release it for the counted run.
                w_cnt_nxt      = CW'(DIV_LATENCY - 1);
                w_div_rstn_nxt = 1'b1;
                w_state_nxt    = div_sched_pkg::S_RUN;
            end
            div_sched_pkg::S_RUN: begin
                if (r_cnt == '0) begin
                    w_quot_nxt      = div_quotient;
                    w_rem_nxt       = div_remainder;
                    w_dbz_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = div_sched_pkg::S_HOLD;
                end else begin
                    w_cnt_nxt      = r_cnt - CW'(1);
                    w_div_rstn_nxt = 1'b1;
                end
            end
            div_sched_pkg::S_HOLD: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = div_sched_pkg::S_IDLE;
                end
            end
            default: w_state_nxt = div_sched_pkg::S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != div_sched_pkg::S_IDLE);
    end

    assign req_ready     = w_gnt;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_quotient  = r_quot;
    assign rsp_remainder = r_rem;
    assign rsp_dbz       = r_dbz;
    assign busy          = r_busy;
    assign div_rstn      = r_div_rstn;
    assign div_m         = r_div_m;
    assign div_q         = r_div_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_div_scheduler;

    localparam int N    = 48;
    localparam int NREQ = 2;
    localparam int L    = 24;
    localparam int HW   = 24;

    typedef struct {
        int               id;
        logic [HW-1:0]    quot;
        logic [HW-1:0]    rem;
        logic             dbz;
        int               acc;
        int               rise;
    } rsp_t;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][N-1:0] req_m;
    logic [NREQ-1:0][N-1:0] req_q;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [0:0]             rsp_id;
    logic [HW-1:0]          rsp_quotient;
    logic [HW-1:0]          rsp_remainder;
    logic                   rsp_dbz;
    logic                   busy;
    logic                   div_rstn;
    logic [N-1:0]           div_m;
    logic [N-1:0]           div_q;
    logic [HW-1:0]          div_quotient;
    logic [HW-1:0]          div_remainder;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_mode = 0;
    rsp_t obs[$];

    div_scheduler #(.N(N), .NREQ(NREQ), .DIV_LATENCY(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_m         (req_m),
        .req_q         (req_q),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .busy          (busy),
        .div_rstn      (div_rstn),
        .div_m         (div_m),
        .div_q         (div_q),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: correct results only once enough released edges have passed.
    int unsigned dcnt = 0;
    always @(posedge clk) dcnt <= div_rstn ? dcnt + 1 : 0;
    always_comb begin
        if (dcnt >= L - 1 && div_m != '0) begin
            div_quotient  = HW'(div_q / div_m);
            div_remainder = HW'(div_q % div_m);
        end else begin
            div_quotient  = HW'(32'h00A5A5A5 ^ dcnt);
            div_remainder = HW'(32'h005A5A5A + dcnt);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event (t=%0t)", nm, $time);
    endtask

    function automatic logic [HW-1:0] ref_quot(input logic [N-1:0] q, input logic [N-1:0] m);
        return (m == '0) ? '1 : HW'(q / m);
    endfunction

    function automatic logic [HW-1:0] ref_rem(input logic [N-1:0] q, input logic [N-1:0] m);
        return (m == '0) ? '0 : HW'(q % m);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: one transaction in flight, timing expressed as offsets from the accept edge.
    bit            m_busy = 0;
    int            m_ptr = 0;
    int            m_e0 = 0;
    int            m_id = 0;
    int            m_k = 0;
    int            m_g = 0;
    int            m_rise = -1;
    logic [N-1:0]  m_m, m_q;
    logic          m_dz, m_ev, m_er;
    logic [NREQ-1:0] m_ready;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_div_rstn", div_rstn, 0);
            chk("rst_rsp_fields", {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, 0);
            chk("rst_div_ops", {div_m, div_q}, 0);
        end else if (!m_busy) begin
            m_g     = rr_pick(req_valid, m_ptr);
            m_ready = '0;
            if (m_g >= 0) m_ready[m_g] = 1'b1;
            chk("idle_req_ready", req_ready, m_ready);
            chk("idle_busy", busy, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_div_rstn", div_rstn, 0);
            if (m_g >= 0) begin
                m_busy = 1;
                m_e0   = cyc + 1;
                m_id   = m_g;
                m_m    = req_m[m_g];
                m_q    = req_q[m_g];
                m_rise = -1;
                m_ptr  = (m_g + 1) % NREQ;
            end
        end else begin
            m_k  = cyc - m_e0;
            m_dz = (m_m == '0);
            m_ev = m_dz || (m_k >= L + 1);
            m_er = !m_dz && (m_k >= 1) && (m_k <= L);
            chk("run_busy", busy, 1);
            chk("run_req_ready", req_ready, 0);
            chk("run_div_m", div_m, m_m);
            chk("run_div_q", div_q, m_q);
            chk("run_rsp_valid", rsp_valid, m_ev);
            chk("run_div_rstn", div_rstn, m_er);
            if (m_ev) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_quotient", rsp_quotient, ref_quot(m_q, m_m));
                chk("rsp_remainder", rsp_remainder, ref_rem(m_q, m_m));
                chk("rsp_dbz", rsp_dbz, m_dz);
                if (rsp_valid && m_rise < 0) m_rise = cyc;
                if (rsp_ready) begin
                    obs.push_back('{id: int'(rsp_id), quot: rsp_quotient, rem: rsp_remainder,
                                    dbz: rsp_dbz, acc: m_e0, rise: m_rise});
                    m_busy = 0;
                end
            end
        end
    end

    function automatic logic [N-1:0] rand_m();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return N'($urandom_range(1, 15));
            2:       return N'({$urandom(), $urandom()}) | N'(1);
            default: return N'($urandom_range(1, 32'd1 << 20));
        endcase
    endfunction

    function automatic logic [N-1:0] rand_q();
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 1000));
        return N'({$urandom(), $urandom()});
    endfunction

    // One clock: granted requests drop valid; random traffic is applied in random mode.
    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_m[i]     = rand_m();
                    req_q[i]     = rand_q();
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic wait_rsp(output rsp_t r);
        int n;
        n = 0;
        while (obs.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        if (obs.size() == 0) begin
            fail("rsp_timeout");
            r = '{id: -1, quot: '0, rem: '0, dbz: 1'b0, acc: 0, rise: 0};
        end else begin
            r = obs.pop_front();
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] m, input logic [N-1:0] q);
        req_valid[i] = 1'b1;
        req_m[i]     = m;
        req_q[i]     = q;
    endtask

    task automatic chk_rsp(input string nm, input rsp_t r, input int id,
                           input logic [HW-1:0] qu, input logic [HW-1:0] re, input logic dz);
        chk({nm, "_id"}, r.id, id);
        chk({nm, "_quot"}, r.quot, qu);
        chk({nm, "_rem"}, r.rem, re);
        chk({nm, "_dbz"}, r.dbz, dz);
    endtask

    rsp_t r;
    logic [63:0] snap;
    logic [N-1:0] big_m, big_q;
    int n;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b1;

        chk("pin_q_100_7", ref_quot(48'd100, 48'd7), 14);
        chk("pin_r_100_7", ref_rem(48'd100, 48'd7), 2);
        chk("pin_q_17_5", ref_quot(48'd17, 48'd5), 3);
        chk("pin_dbz_q", ref_quot(48'd55, 48'd0), 24'hFFFFFF);

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Simultaneous requests from pointer 0
        set_req(0, 48'd3, 48'd10);
        set_req(1, 48'd5, 48'd17);
        wait_rsp(r); chk_rsp("sim1_first", r, 0, 3, 1, 0);
        wait_rsp(r); chk_rsp("sim1_second", r, 1, 3, 2, 0);

        // Single request and its latency
        set_req(0, 48'd7, 48'd100);
        wait_rsp(r); chk_rsp("single", r, 0, 14, 2, 0);
        chk("single_latency", r.rise - r.acc, 25);

        // Repeat simultaneous: pointer now favours requester 1
        set_req(0, 48'd3, 48'd10);
        set_req(1, 48'd5, 48'd17);
        wait_rsp(r); chk_rsp("sim2_first", r, 1, 3, 2, 0);
        wait_rsp(r); chk_rsp("sim2_second", r, 0, 3, 1, 0);

        // Divide by zero
        set_req(1, 48'd0, 48'd55);
        wait_rsp(r); chk_rsp("dbz", r, 1, 24'hFFFFFF, 0, 1);
        chk("dbz_latency", r.rise - r.acc, 0);

        // Backpressure with a competing request waiting
        rsp_ready = 1'b0;
        set_req(0, 48'd9, 48'd50);
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        if (!rsp_valid) fail("bp_wait_valid");
        snap = 64'({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz});
        set_req(1, 48'd4, 48'd30);
        repeat (10) begin
            tick();
            chk("bp_stable", {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, snap);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_busy", busy, 0);
        wait_rsp(r); chk_rsp("bp_held", r, 0, 5, 5, 0);
        wait_rsp(r); chk_rsp("bp_next", r, 1, 7, 2, 0);

        // Reset five cycles into the run
        set_req(0, 48'd13, 48'd1000);
        n = 0;
        while (!busy && n < 50) begin tick(); n++; end
        if (!busy) fail("rst_wait_accept");
        tick();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_div_rstn", div_rstn, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_no_rsp", obs.size(), 0);
        set_req(0, 48'd13, 48'd1000);
        set_req(1, 48'd6, 48'd45);
        wait_rsp(r); chk_rsp("post_rst_first", r, 0, 76, 12, 0);
        chk("post_rst_latency", r.rise - r.acc, 25);
        wait_rsp(r); chk_rsp("post_rst_second", r, 1, 7, 3, 0);

        // Large operands (dividend truncated to the port width)
        big_m = 48'd2657890056;
        big_q = 48'(64'd356478892927895);
        set_req(0, big_m, big_q);
        wait_rsp(r); chk_rsp("large", r, 0, ref_quot(big_q, big_m), ref_rem(big_q, big_m), 0);

        // Random traffic with backpressure, withdrawals and zero divisors
        rand_mode = 1;
        repeat (2500) tick();
        rand_mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("drain_idle", busy, 0);
        obs.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
